// File: rtl/branch_target_table.sv
// Runtime-loadable, multi-bank branch target table.
// Fetch presents a bank and an index and receives a registered PC target one
// cycle later. A valid/ready loader streams targets into one bank at a time.
module branch_target_table #(
   parameter int D     = 10,
   parameter int A     = 8,
   parameter int BANKS = 2,
   parameter int DEPTH = 16,
   localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [BW-1:0] i_bank_sel,
   input  logic [A-1:0]  i_addr,
   input  logic          i_branch,
   output logic [D-1:0]  o_target,
   output logic          o_target_valid,
   output logic          o_miss,
   input  logic          i_load_start,
   input  logic [BW-1:0] i_load_bank,
   input  logic          i_load_valid,
   input  logic [D-1:0]  i_load_data,
   input  logic          i_load_last,
   output logic          o_load_ready,
   output logic          o_load_done,
   output logic          o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [BW-1:0]   r_load_bank;
   logic            r_load_ready;
   logic            r_load_done;
   logic            r_busy;
   logic [D-1:0]    r_mem   [BANKS][DEPTH];
   logic [DEPTH-1:0] r_valid [BANKS];

   logic [D-1:0]    r_target;
   logic            r_target_valid;
   logic            r_miss;

   logic            w_bank_ok;
   logic            w_addr_ok;
   logic            w_load_bank_ok;
   logic [IW-1:0]   w_idx;
   logic            w_beat;
   logic            w_loading_sel;
   logic            w_hit;

   assign w_bank_ok      = 32'(i_bank_sel) < BANKS;
   assign w_addr_ok      = 32'(i_addr) < DEPTH;
   assign w_load_bank_ok = 32'(i_load_bank) < BANKS;
   assign w_idx          = i_addr[IW-1:0];
   assign w_beat         = (r_state == S_LOAD) && i_load_valid && r_load_ready;
   // A bank under load is never trusted: its valid bits are being rebuilt.
   assign w_loading_sel  = (r_state == S_LOAD) && (r_load_bank == i_bank_sel);
   assign w_hit          = w_bank_ok && w_addr_ok && !w_loading_sel
                           && r_valid[i_bank_sel][w_idx];

   assign o_target       = r_target;
   assign o_target_valid = r_target_valid;
   assign o_miss         = r_miss;
   assign o_load_ready   = r_load_ready;
   assign o_load_done    = r_load_done;
   assign o_busy         = r_busy;

   // Loader FSM: owns the table contents, valid bits and registered loader outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_load_bank  <= '0;
         r_load_ready <= 1'b0;
         r_load_done  <= 1'b0;
         r_busy       <= 1'b0;
         for (int b = 0; b < BANKS; b++) begin
            r_valid[b] <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               r_mem[b][e] <= '0;
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_load_start && w_load_bank_ok) begin
                  r_state              <= S_LOAD;
                  r_ptr                <= '0;
                  r_load_bank          <= i_load_bank;
                  r_valid[i_load_bank] <= '0;
                  r_load_ready         <= 1'b1;
                  r_busy               <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_beat) begin
                  r_mem[r_load_bank][r_ptr]   <= i_load_data;
                  r_valid[r_load_bank][r_ptr] <= 1'b1;
                  // The pointer stops at the last entry rather than wrapping.
                  if ((r_ptr == IW'(DEPTH - 1)) || i_load_last) begin
                     r_state      <= S_DONE;
                     r_load_ready <= 1'b0;
                     r_load_done  <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_load_done <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state      <= S_IDLE;
               r_load_ready <= 1'b0;
               r_load_done  <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   // Lookup pipeline: one registered result per branch request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_target       <= '0;
         r_target_valid <= 1'b0;
         r_miss         <= 1'b0;
      end else begin
         r_target_valid <= i_branch;
         r_miss         <= i_branch && !w_hit;
         r_target       <= (i_branch && w_hit) ? r_mem[i_bank_sel][w_idx] : '0;
      end
   end

endmodule
